// File: rtl/sa_write_channel_pkg.sv
// Shared write-channel definitions: AXI field widths, burst and response
// encodings, and the slave-side ID construction rule.
package sa_write_channel_pkg;

    localparam int AXI_MST_ID_W = 5;
    localparam int AXI_BURST_W  = 2;
    localparam int AXI_LEN_W    = 3;
    localparam int AXI_SIZE_W   = 3;
    localparam int AXI_RESP_W   = 2;

    typedef enum logic [AXI_BURST_W-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [AXI_RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    // Slave-side ID is {master index, master AxID}; the index occupies the MSBs.
    function automatic int slv_id_w(input int mst_id_w, input int mst_amt);
        return mst_id_w + $clog2(mst_amt);
    endfunction

endpackage

// File: rtl/sa_wr_order_fifo.sv
// Write-order FIFO: remembers which master owns each granted AW until its
// W burst finishes. DEPTH must be a power of two.
module sa_wr_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sa_write_channel.sv
// Slave-side write channel: round-robin AW merge, W steering in grant order,
// and B demux back to the originating master by the ID's master-index MSBs.
module sa_write_channel
    import sa_write_channel_pkg::*;
#(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = AXI_MST_ID_W,
    parameter int TRANS_BURST_W     = AXI_BURST_W,
    parameter int TRANS_DATA_LEN_W  = AXI_LEN_W,
    parameter int TRANS_DATA_SIZE_W = AXI_SIZE_W,
    parameter int TRANS_WR_RESP_W   = AXI_RESP_W,
    parameter int MST_ID_W          = $clog2(MST_AMT),
    parameter int TRANS_SLV_ID_W    = slv_id_w(TRANS_MST_ID_W, MST_AMT)
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESET_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
    input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
    output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
    input  logic [DATA_WIDTH*MST_AMT-1:0]          dsp_WDATA_i,
    input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
    input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
    input  logic [MST_AMT-1:0]                     dsp_WDATA_sel_i,
    output logic [MST_AMT-1:0]                     dsp_WREADY_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_BID_o,
    output logic [TRANS_WR_RESP_W*MST_AMT-1:0]     dsp_BRESP_o,
    output logic [MST_AMT-1:0]                     dsp_BVALID_o,
    input  logic [MST_AMT-1:0]                     dsp_BREADY_i,
    output logic [TRANS_SLV_ID_W-1:0]              s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
    output logic                                   s_AWVALID_o,
    input  logic                                   s_AWREADY_i,
    output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
    output logic                                   s_WLAST_o,
    output logic                                   s_WVALID_o,
    input  logic                                   s_WREADY_i,
    input  logic [TRANS_SLV_ID_W-1:0]              s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]             s_BRESP_i,
    input  logic                                   s_BVALID_i,
    output logic                                   s_BREADY_o
);

    localparam int CNT_W = $clog2(OUTSTANDING_AMT) + 1;

    logic [TRANS_MST_ID_W-1:0]    aw_id_arr    [MST_AMT];
    logic [ADDR_WIDTH-1:0]        aw_addr_arr  [MST_AMT];
    logic [TRANS_BURST_W-1:0]     aw_burst_arr [MST_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  aw_len_arr   [MST_AMT];
    logic [TRANS_DATA_SIZE_W-1:0] aw_size_arr  [MST_AMT];
    logic [DATA_WIDTH-1:0]        w_data_arr   [MST_AMT];
    logic [TRANS_MST_ID_W-1:0]    b_id_arr     [MST_AMT];
    logic [TRANS_WR_RESP_W-1:0]   b_resp_arr   [MST_AMT];

    logic                aw_vld;
    logic                aw_free;
    logic                arb_en;
    logic                aw_grant;
    logic                gnt_vld;
    logic [MST_ID_W-1:0] gnt_idx;
    logic [MST_ID_W-1:0] cand;
    logic [MST_ID_W-1:0] rr_ptr;
    logic [MST_ID_W-1:0] w_head;
    logic                order_full;
    logic                order_empty;
    logic                w_pop;
    logic [CNT_W-1:0]    unused_order_cnt;
    logic [MST_ID_W-1:0] b_idx;
    logic                b_idx_ok;

    for (genvar g = 0; g < MST_AMT; g++) begin : g_lanes
        assign aw_id_arr[g]    = dsp_AWID_i[g*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        assign aw_addr_arr[g]  = dsp_AWADDR_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign aw_burst_arr[g] = dsp_AWBURST_i[g*TRANS_BURST_W +: TRANS_BURST_W];
        assign aw_len_arr[g]   = dsp_AWLEN_i[g*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        assign aw_size_arr[g]  = dsp_AWSIZE_i[g*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        assign w_data_arr[g]   = dsp_WDATA_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign dsp_BID_o[g*TRANS_MST_ID_W +: TRANS_MST_ID_W]     = b_id_arr[g];
        assign dsp_BRESP_o[g*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = b_resp_arr[g];
    end

    // Full is judged on the pre-pop occupancy, so a pop never enables a same-cycle grant.
    assign aw_free  = !aw_vld || s_AWREADY_i;
    assign arb_en   = aw_free && !order_full;
    assign aw_grant = arb_en && gnt_vld && !ARESET_i;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            cand = MST_ID_W'((int'(rr_ptr) + i) % MST_AMT);
            if (!gnt_vld && dsp_AWVALID_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        dsp_AWREADY_o = '0;
        if (aw_grant) dsp_AWREADY_o[gnt_idx] = 1'b1;
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            aw_vld      <= 1'b0;
            rr_ptr      <= '0;
            s_AWID_o    <= '0;
            s_AWADDR_o  <= '0;
            s_AWBURST_o <= '0;
            s_AWLEN_o   <= '0;
            s_AWSIZE_o  <= '0;
        end else if (aw_grant) begin
            aw_vld      <= 1'b1;
            rr_ptr      <= (gnt_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : gnt_idx + 1'b1;
            s_AWID_o    <= {gnt_idx, aw_id_arr[gnt_idx]};
            s_AWADDR_o  <= aw_addr_arr[gnt_idx];
            s_AWBURST_o <= aw_burst_arr[gnt_idx];
            s_AWLEN_o   <= aw_len_arr[gnt_idx];
            s_AWSIZE_o  <= aw_size_arr[gnt_idx];
        end else if (s_AWREADY_i) begin
            aw_vld <= 1'b0;
        end
    end

    assign s_AWVALID_o = aw_vld;

    sa_wr_order_fifo #(
        .WIDTH (MST_ID_W),
        .DEPTH (OUTSTANDING_AMT),
        .CNT_W (CNT_W)
    ) u_order_fifo (
        .clk       (ACLK_i),
        .rst       (ARESET_i),
        .push      (aw_grant),
        .push_data (gnt_idx),
        .pop       (w_pop),
        .head      (w_head),
        .full      (order_full),
        .empty     (order_empty),
        .count     (unused_order_cnt)
    );

    always_comb begin
        s_WVALID_o   = 1'b0;
        s_WLAST_o    = 1'b0;
        s_WDATA_o    = '0;
        dsp_WREADY_o = '0;
        if (!order_empty) begin
            s_WVALID_o           = dsp_WVALID_i[w_head] & dsp_WDATA_sel_i[w_head];
            s_WLAST_o            = dsp_WLAST_i[w_head];
            s_WDATA_o            = w_data_arr[w_head];
            dsp_WREADY_o[w_head] = s_WREADY_i & dsp_WDATA_sel_i[w_head];
        end
    end

    assign w_pop = s_WVALID_o & s_WREADY_i & s_WLAST_o;

    // Responses carrying an index with no matching master are accepted and dropped.
    assign b_idx      = s_BID_i[TRANS_SLV_ID_W-1 -: MST_ID_W];
    assign b_idx_ok   = ({1'b0, b_idx} < (MST_ID_W + 1)'(MST_AMT));
    assign s_BREADY_o = b_idx_ok ? dsp_BREADY_i[b_idx] : 1'b1;

    always_comb begin
        dsp_BVALID_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            b_id_arr[i]   = '0;
            b_resp_arr[i] = '0;
        end
        if (b_idx_ok && !ARESET_i) begin
            dsp_BVALID_o[b_idx] = s_BVALID_i;
            b_id_arr[b_idx]     = s_BID_i[TRANS_MST_ID_W-1:0];
            b_resp_arr[b_idx]   = s_BRESP_i;
        end
    end

endmodule

// File: tb/tb_sa_write_channel.sv
// Randomized bench for sa_write_channel against a queue-based transaction model.
module tb_sa_write_channel;
    import sa_write_channel_pkg::*;

    localparam int MST  = 2;
    localparam int OUT  = 8;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int IDW  = 5;
    localparam int MIW  = 1;
    localparam int SIDW = IDW + MIW;
    localparam int BW   = 2;
    localparam int LW   = 3;
    localparam int ZW   = 3;
    localparam int RW   = 2;

    logic clk = 1'b0;
    logic rst;

    logic [IDW*MST-1:0] awid;
    logic [AW*MST-1:0]  awaddr;
    logic [BW*MST-1:0]  awburst;
    logic [LW*MST-1:0]  awlen;
    logic [ZW*MST-1:0]  awsize;
    logic [MST-1:0]     awvalid, awready;
    logic [DW*MST-1:0]  wdata;
    logic [MST-1:0]     wlast, wvalid, wsel, wready;
    logic [IDW*MST-1:0] bid_o;
    logic [RW*MST-1:0]  bresp_o;
    logic [MST-1:0]     bvalid_o, bready;
    logic [SIDW-1:0]    s_awid;
    logic [AW-1:0]      s_awaddr;
    logic [BW-1:0]      s_awburst;
    logic [LW-1:0]      s_awlen;
    logic [ZW-1:0]      s_awsize;
    logic               s_awvalid, s_awready;
    logic [DW-1:0]      s_wdata;
    logic               s_wlast, s_wvalid, s_wready;
    logic [SIDW-1:0]    s_bid;
    logic [RW-1:0]      s_bresp;
    logic               s_bvalid, s_bready;

    always #5 clk = ~clk;

    sa_write_channel dut (
        .ACLK_i(clk), .ARESET_i(rst),
        .dsp_AWID_i(awid), .dsp_AWADDR_i(awaddr), .dsp_AWBURST_i(awburst),
        .dsp_AWLEN_i(awlen), .dsp_AWSIZE_i(awsize),
        .dsp_AWVALID_i(awvalid), .dsp_AWREADY_o(awready),
        .dsp_WDATA_i(wdata), .dsp_WLAST_i(wlast), .dsp_WVALID_i(wvalid),
        .dsp_WDATA_sel_i(wsel), .dsp_WREADY_o(wready),
        .dsp_BID_o(bid_o), .dsp_BRESP_o(bresp_o), .dsp_BVALID_o(bvalid_o),
        .dsp_BREADY_i(bready),
        .s_AWID_o(s_awid), .s_AWADDR_o(s_awaddr), .s_AWBURST_o(s_awburst),
        .s_AWLEN_o(s_awlen), .s_AWSIZE_o(s_awsize),
        .s_AWVALID_o(s_awvalid), .s_AWREADY_i(s_awready),
        .s_WDATA_o(s_wdata), .s_WLAST_o(s_wlast), .s_WVALID_o(s_wvalid),
        .s_WREADY_i(s_wready),
        .s_BID_i(s_bid), .s_BRESP_i(s_bresp), .s_BVALID_i(s_bvalid),
        .s_BREADY_o(s_bready)
    );

    typedef struct {
        int cycles;
        int p_awv;
        int p_awr;
        int p_wv;
        int p_wr;
        bit rst_before;
    } phase_t;

    phase_t phases [6] = '{
        '{200,  60,  80,  60,  80, 1'b0},
        '{ 40, 100, 100,   0, 100, 1'b0},
        '{120, 100, 100,  30, 100, 1'b0},
        '{150,  90,  30,  70,  50, 1'b1},
        '{200,  50,  90,  90,  90, 1'b0},
        '{150, 100, 100,  80, 100, 1'b0}
    };

    // Reference model: registered AW slot, queue of granted masters, RR pointer.
    bit             m_aw_vld;
    logic [SIDW-1:0] m_aw_id;
    logic [AW-1:0]  m_aw_addr;
    logic [BW-1:0]  m_aw_burst;
    logic [LW-1:0]  m_aw_len;
    logic [ZW-1:0]  m_aw_size;
    int             order_q [$];
    int             rr;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic model_reset();
        m_aw_vld = 1'b0;
        order_q.delete();
        rr = 0;
    endtask

    task automatic clear_inputs();
        awid = '0; awaddr = '0; awburst = '0; awlen = '0; awsize = '0; awvalid = '0;
        wdata = '0; wlast = '0; wvalid = '0; wsel = '0; bready = '0;
        s_awready = 1'b0; s_wready = 1'b0;
        s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
    endtask

    task automatic drive_random(input phase_t p);
        for (int i = 0; i < MST; i++) begin
            awvalid[i]              = rnd(p.p_awv);
            awid[i*IDW +: IDW]      = IDW'($urandom);
            awaddr[i*AW +: AW]      = $urandom;
            awburst[i*BW +: BW]     = BW'($urandom_range(2, 0));
            awlen[i*LW +: LW]       = LW'($urandom);
            awsize[i*ZW +: ZW]      = ZW'($urandom_range(2, 0));
            wvalid[i]               = rnd(p.p_wv);
            wsel[i]                 = rnd(85);
            wlast[i]                = rnd(35);
            wdata[i*DW +: DW]       = $urandom;
            bready[i]               = rnd(70);
        end
        s_awready = rnd(p.p_awr);
        s_wready  = rnd(p.p_wr);
        s_bid     = SIDW'($urandom);
        s_bresp   = RW'($urandom);
        s_bvalid  = rnd(50);
    endtask

    task automatic check_reset_outputs(input string tag);
        int m;
        m = int'(s_bid[SIDW-1]);
        check_val({tag, "_awready"}, awready, '0);
        check_val({tag, "_wready"}, wready, '0);
        check_val({tag, "_bvalid"}, bvalid_o, '0);
        check_val({tag, "_awvalid"}, s_awvalid, 0);
        check_val({tag, "_wvalid"}, s_wvalid, 0);
        check_val({tag, "_wlast"}, s_wlast, 0);
        check_val({tag, "_awid"}, s_awid, 0);
        check_val({tag, "_awaddr"}, s_awaddr, 0);
        check_val({tag, "_wdata"}, s_wdata, 0);
        check_val({tag, "_bid"}, bid_o, 0);
        check_val({tag, "_bresp"}, bresp_o, 0);
        check_val({tag, "_bready"}, s_bready, bready[m]);
    endtask

    // Compare DUT outputs for the current cycle, then advance the model across the edge.
    task automatic check_cycle();
        int k;
        int h;
        int m;
        bit pop;
        logic [MST-1:0] exp_awr, exp_wr, exp_bv;
        logic exp_wv;

        k = -1;
        if ((!m_aw_vld || s_awready) && order_q.size() < OUT) begin
            for (int i = 0; i < MST; i++) begin
                int c;
                c = (rr + i) % MST;
                if (k < 0 && awvalid[c]) k = c;
            end
        end
        exp_awr = '0;
        if (k >= 0) exp_awr[k] = 1'b1;
        check_val("aw_ready", awready, exp_awr);

        check_val("aw_valid", s_awvalid, m_aw_vld);
        if (m_aw_vld) begin
            check_val("aw_id", s_awid, m_aw_id);
            check_val("aw_addr", s_awaddr, m_aw_addr);
            check_val("aw_burst", s_awburst, m_aw_burst);
            check_val("aw_len", s_awlen, m_aw_len);
            check_val("aw_size", s_awsize, m_aw_size);
        end

        exp_wv = 1'b0;
        exp_wr = '0;
        pop    = 1'b0;
        if (order_q.size() > 0) begin
            h = order_q[0];
            exp_wv    = wvalid[h] & wsel[h];
            exp_wr[h] = s_wready & wsel[h];
            check_val("w_data", s_wdata, wdata[h*DW +: DW]);
            check_val("w_last", s_wlast, wlast[h]);
            pop = exp_wv && s_wready && wlast[h];
        end
        check_val("w_valid", s_wvalid, exp_wv);
        check_val("w_ready", wready, exp_wr);

        m = int'(s_bid[SIDW-1]);
        exp_bv    = '0;
        exp_bv[m] = s_bvalid;
        check_val("b_valid", bvalid_o, exp_bv);
        check_val("b_id", bid_o[m*IDW +: IDW], s_bid[IDW-1:0]);
        check_val("b_resp", bresp_o[m*RW +: RW], s_bresp);
        check_val("b_ready", s_bready, bready[m]);

        if (k >= 0) begin
            m_aw_vld   = 1'b1;
            m_aw_id    = {MIW'(k), awid[k*IDW +: IDW]};
            m_aw_addr  = awaddr[k*AW +: AW];
            m_aw_burst = awburst[k*BW +: BW];
            m_aw_len   = awlen[k*LW +: LW];
            m_aw_size  = awsize[k*ZW +: ZW];
            rr         = (k + 1) % MST;
        end else if (s_awready) begin
            m_aw_vld = 1'b0;
        end
        if (pop) void'(order_q.pop_front());
        if (k >= 0) order_q.push_back(k);
    endtask

    task automatic reset_mid_run();
        phase_t all_on;
        all_on = '{1, 100, 100, 100, 100, 1'b0};
        @(posedge clk);
        #1;
        drive_random(all_on);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        s_bid    = {1'b1, 5'd7};
        s_bresp  = RESP_SLVERR;
        s_bvalid = 1'b1;
        bready   = 2'b10;
        awvalid  = 2'b11;
        model_reset();
        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b0;

        foreach (phases[p]) begin
            if (phases[p].rst_before) reset_mid_run();
            repeat (phases[p].cycles) begin
                @(posedge clk);
                #1;
                drive_random(phases[p]);
                @(negedge clk);
                check_cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
